// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared encodings for the forwarding/hazard unit: forward select codes
// and the stage-index to select-code mapping.
package fwd_pkg;

  localparam int FWD_RF = 0;

  // Select codes of the original two-stage unit, kept bit-identical.
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Youngest stage gets the highest code so the legacy encoding falls out at 2 stages.
  function automatic int fwd_code(input int num_stages, input int i);
    return num_stages - i;
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_src_resolve.sv
// Resolves one source operand against the forwarding stages and the
// long-latency busy bit for that register.
module fwd_src_resolve
  import fwd_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int NUM_STAGES = 2,
  parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_W-1:0]                  src,
  input  logic                              used,
  input  logic [NUM_STAGES-1:0][REG_W-1:0]  stg_rd,
  input  logic [NUM_STAGES-1:0]             stg_reg_write,
  input  logic [NUM_STAGES-1:0]             stg_data_ok,
  input  logic                              src_busy,
  output logic [FWD_W-1:0]                  fwd,
  output logic                              src_stall
);

  logic hit;

  // Youngest hit wins; an in-flight load in a young stage masks older copies.
  always_comb begin
    fwd       = FWD_W'(FWD_RF);
    src_stall = 1'b0;
    hit       = 1'b0;
    if (used && src != '0) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (!hit && stg_reg_write[i] && stg_rd[i] == src) begin
          hit = 1'b1;
          if (stg_data_ok[i]) fwd = FWD_W'(fwd_code(NUM_STAGES, i));
          else                src_stall = 1'b1;
        end
      end
      if (!hit && src_busy) src_stall = 1'b1;
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// ID/EX forwarding and hazard unit: N-stage operand forwarding, load-use
// stall, and a per-register countdown scoreboard for long-latency ops.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int NREGS      = 32,
  parameter int NUM_STAGES = 2,
  parameter int MAX_LAT    = 8,
  parameter int LAT_W      = $clog2(MAX_LAT + 1),
  parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [REG_W-1:0]              id_rs1,
  input  logic [REG_W-1:0]              id_rs2,
  input  logic                          id_use_rs1,
  input  logic                          id_use_rs2,
  input  logic [REG_W-1:0]              id_rd,
  input  logic                          id_reg_write,
  input  logic [LAT_W-1:0]              id_lat,
  input  logic                          flush,
  input  logic [NUM_STAGES*REG_W-1:0]   stg_rd,
  input  logic [NUM_STAGES-1:0]         stg_reg_write,
  input  logic [NUM_STAGES-1:0]         stg_data_ok,
  output logic [FWD_W-1:0]              forward_a,
  output logic [FWD_W-1:0]              forward_b,
  output logic                          stall,
  output logic [NREGS-1:0]              sb_busy,
  output logic [31:0]                   stall_count
);

  localparam int NSRC = 2;

  logic [NREGS-1:0][LAT_W-1:0]       cnt;
  logic [NUM_STAGES-1:0][REG_W-1:0]  stg_rd_arr;
  logic [NSRC-1:0][REG_W-1:0]        src;
  logic [NSRC-1:0]                   src_used;
  logic [NSRC-1:0]                   src_busy;
  logic [NSRC-1:0][FWD_W-1:0]        src_fwd;
  logic [NSRC-1:0]                   src_stall;
  logic                              waw;
  logic                              accept;
  logic                              sb_load;
  logic [LAT_W-1:0]                  lat_clamp;

  assign stg_rd_arr = stg_rd;
  assign src        = {id_rs2, id_rs1};
  assign src_used   = {id_use_rs2, id_use_rs1};

  genvar r;
  generate
    for (r = 0; r < NREGS; r++) begin : g_busy
      assign sb_busy[r] = |cnt[r];
    end
  endgenerate

  genvar s;
  generate
    for (s = 0; s < NSRC; s++) begin : g_src
      assign src_busy[s] = sb_busy[src[s]];
      fwd_src_resolve #(
        .REG_W      (REG_W),
        .NUM_STAGES (NUM_STAGES),
        .FWD_W      (FWD_W)
      ) u_res (
        .src           (src[s]),
        .used          (src_used[s]),
        .stg_rd        (stg_rd_arr),
        .stg_reg_write (stg_reg_write),
        .stg_data_ok   (stg_data_ok),
        .src_busy      (src_busy[s]),
        .fwd           (src_fwd[s]),
        .src_stall     (src_stall[s])
      );
    end
  endgenerate

  // Re-issuing to a register with a long op still outstanding would let the
  // older writeback land on top of the younger one.
  assign waw = id_valid && id_reg_write && id_rd != '0 && sb_busy[id_rd];

  assign stall     = id_valid && !flush && (src_stall[0] || src_stall[1] || waw);
  assign forward_a = id_valid ? src_fwd[0] : FWD_W'(FWD_RF);
  assign forward_b = id_valid ? src_fwd[1] : FWD_W'(FWD_RF);

  assign accept    = id_valid && !stall && !flush;
  assign sb_load   = accept && id_reg_write && id_rd != '0 && id_lat != '0;
  assign lat_clamp = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
      if (sb_load) cnt[id_rd] <= lat_clamp;
      cnt[0] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                               stall_count <= '0;
    else if (stall && stall_count != '1)   stall_count <= stall_count + 32'd1;
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed checks of forwarding priority, load-use, long-latency scoreboard,
// WAW/flush, reset, and a 3-stage build.
module tb_fwd_hazard_scoreboard;

  localparam int REG_W = 5;
  localparam int LAT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_use_rs1, id_use_rs2, id_reg_write, flush;
  logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
  logic [LAT_W-1:0]  id_lat;
  logic [2*REG_W-1:0] stg_rd;
  logic [1:0]        stg_reg_write, stg_data_ok;
  logic [1:0]        forward_a, forward_b;
  logic              stall;
  logic [31:0]       sb_busy;
  logic [31:0]       stall_count;

  logic [3*REG_W-1:0] stg_rd3;
  logic [2:0]         stg_reg_write3, stg_data_ok3;
  logic [1:0]         forward_a3, forward_b3;
  logic               stall3;
  logic [31:0]        sb_busy3, stall_count3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard #(.NUM_STAGES(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_lat(id_lat), .flush(flush),
    .stg_rd(stg_rd), .stg_reg_write(stg_reg_write), .stg_data_ok(stg_data_ok),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .sb_busy(sb_busy), .stall_count(stall_count)
  );

  fwd_hazard_scoreboard #(.NUM_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_lat(id_lat), .flush(flush),
    .stg_rd(stg_rd3), .stg_reg_write(stg_reg_write3), .stg_data_ok(stg_data_ok3),
    .forward_a(forward_a3), .forward_b(forward_b3), .stall(stall3),
    .sb_busy(sb_busy3), .stall_count(stall_count3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_lat = 0; flush = 0;
    stg_rd = 0; stg_reg_write = 0; stg_data_ok = 0;
    stg_rd3 = 0; stg_reg_write3 = 0; stg_data_ok3 = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", sb_busy, 32'h0);
    chk("rst_scnt", stall_count, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // youngest stage wins
    id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
    stg_rd = {5'd5, 5'd5}; stg_reg_write = 2'b11; stg_data_ok = 2'b11;
    #1;
    chk("young_fa", {30'd0, forward_a}, 32'd2);
    chk("young_stall", {31'd0, stall}, 32'd0);
    id_valid = 0; #1;
    chk("novalid_fa", {30'd0, forward_a}, 32'd0);

    // stage1 only
    id_valid = 1; id_use_rs1 = 0; id_rs2 = 7; id_use_rs2 = 1;
    stg_rd = {5'd7, 5'd0}; stg_reg_write = 2'b10; stg_data_ok = 2'b11;
    #1;
    chk("s1_fb", {30'd0, forward_b}, 32'd1);
    id_use_rs2 = 0; #1;
    chk("unused_fb", {30'd0, forward_b}, 32'd0);
    id_use_rs2 = 1; id_rs2 = 0; stg_rd = {5'd0, 5'd0}; #1;
    chk("r0_fb", {30'd0, forward_b}, 32'd0);

    // load-use: young in-flight load blocks older ready copy
    id_use_rs2 = 0; id_rs2 = 0; id_rs1 = 3; id_use_rs1 = 1;
    stg_rd = {5'd3, 5'd3}; stg_reg_write = 2'b11; stg_data_ok = 2'b10;
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_fa", {30'd0, forward_a}, 32'd0);
    flush = 1; #1;
    chk("lu_flush", {31'd0, stall}, 32'd0);
    flush = 0;
    tick();
    stg_data_ok = 2'b11; #1;
    chk("lu_fa2", {30'd0, forward_a}, 32'd2);
    chk("lu_stall2", {31'd0, stall}, 32'd0);
    chk("lu_scnt", stall_count, 32'd1);

    // long op, lat 4
    stg_reg_write = 0; id_use_rs1 = 0;
    id_rd = 9; id_reg_write = 1; id_lat = 4; #1;
    chk("lo_issue", {31'd0, stall}, 32'd0);
    tick();
    id_reg_write = 0; id_lat = 0; id_rd = 0; id_rs1 = 9; id_use_rs1 = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("lo_stall%0d", k), {31'd0, stall}, 32'd1);
      chk($sformatf("lo_busy%0d", k), {31'd0, sb_busy[9]}, 32'd1);
      tick();
    end
    chk("lo_rel", {31'd0, stall}, 32'd0);
    chk("lo_idle", {31'd0, sb_busy[9]}, 32'd0);

    // lat 12 clamps to 8
    id_use_rs1 = 0; id_rd = 10; id_reg_write = 1; id_lat = 12; #1;
    tick();
    id_reg_write = 0; id_lat = 0; id_rd = 0; id_rs2 = 10; id_use_rs2 = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("cl_stall%0d", k), {31'd0, stall}, 32'd1);
      tick();
    end
    chk("cl_rel", {31'd0, stall}, 32'd0);
    chk("cl_scnt", stall_count, 32'd13);

    // WAW then flush: entry kept, no rewrite
    id_use_rs2 = 0; id_rd = 9; id_reg_write = 1; id_lat = 4; #1;
    tick();
    id_lat = 2; #1;
    chk("waw_stall", {31'd0, stall}, 32'd1);
    flush = 1; #1;
    chk("waw_flush", {31'd0, stall}, 32'd0);
    tick();
    flush = 0; id_valid = 0;
    tick(); tick();
    chk("flush_keep", {31'd0, sb_busy[9]}, 32'd1);
    chk("flush_scnt", stall_count, 32'd13);
    tick();
    chk("flush_done", {31'd0, sb_busy[9]}, 32'd0);

    // reset mid-operation
    id_valid = 1; id_rd = 9; id_reg_write = 1; id_lat = 4; #1;
    tick();
    id_valid = 0; id_reg_write = 0; id_lat = 0;
    tick();
    chk("pre_rst_busy", {31'd0, sb_busy[9]}, 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst2_busy", sb_busy, 32'h0);
    chk("rst2_scnt", stall_count, 32'd0);

    // three-stage build
    id_valid = 1; id_rs1 = 6; id_use_rs1 = 1; id_rd = 0;
    stg_rd3 = {5'd6, 5'd0, 5'd0}; stg_reg_write3 = 3'b100; stg_data_ok3 = 3'b111;
    #1;
    chk("s3_st2", {30'd0, forward_a3}, 32'd1);
    stg_rd3 = {5'd6, 5'd6, 5'd0}; stg_reg_write3 = 3'b110; #1;
    chk("s3_st1", {30'd0, forward_a3}, 32'd2);
    stg_rd3 = {5'd6, 5'd6, 5'd6}; stg_reg_write3 = 3'b111; #1;
    chk("s3_st0", {30'd0, forward_a3}, 32'd3);
    stg_data_ok3 = 3'b110; #1;
    chk("s3_lu", {31'd0, stall3}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the two-stage forwarding unit. Generalises operand forwarding to NUM_STAGES pipeline stages.
- Adds load-use stall detection for stages whose result is not yet available.
- Adds a per-register countdown scoreboard for long-latency ops (iterative mul/div) that complete outside the forwarding stages.
- Sits at the ID/EX boundary. Drives the operand muxes and the pipeline stall line.

Parameters:
- REG_W, 5, register address width.
- NREGS, 32, architectural register count (2**REG_W).
- NUM_STAGES, 2, forwarding-source stages; index 0 = youngest (EX/MEM).
- MAX_LAT, 8, max long-latency countdown in cycles.
- LAT_W, $clog2(MAX_LAT+1), countdown width.
- FWD_W, $clog2(NUM_STAGES+1), forward select width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  instruction present at ID/EX
- id_rs1, id_rs2  in  REG_W  source registers
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_rd  in  REG_W  destination register
- id_reg_write  in  1  instruction writes rd
- id_lat  in  LAT_W  0 = normal pipelined op; >0 = long-latency writeback delay in cycles
- flush  in  1  kill the instruction at ID/EX this cycle
- stg_rd  in  NUM_STAGES*REG_W  flattened stage destinations; stage i at [i*REG_W +: REG_W]
- stg_reg_write  in  NUM_STAGES  stage i writes its rd
- stg_data_ok  in  NUM_STAGES  stage i result available for forwarding (0 = load still in flight)
- forward_a, forward_b  out  FWD_W  0 = regfile; code NUM_STAGES-i = forward from stage i
- stall  out  1  hold IF/ID and ID/EX, insert bubble
- sb_busy  out  NREGS  bit r set while cnt[r] != 0
- stall_count  out  32  saturating count of stalled cycles

Behaviour:
- Clock and reset: single clock clk; rst synchronous active-high.
- Reset: all cnt[r]=0, stall_count=0. Hence sb_busy=0.
- forward_*/stall are combinational and not gated by rst.
- Legacy encoding: with NUM_STAGES=2, stage0 -> 2'b10 and stage1 -> 2'b01, matching the prior unit.
- Per-source resolution (src = rs1 or rs2, used = id_use_*):
  - Scan stages i = 0..NUM_STAGES-1. The first hit is stg_reg_write[i] && stg_rd_i != 0 && stg_rd_i == src.
  - Hit with stg_data_ok[i]=1: fwd = NUM_STAGES-i, no stall.
  - Hit with stg_data_ok[i]=0: fwd = 0, src_stall = 1. Older stages are never used past a younger hit.
  - No hit and cnt[src] != 0: src_stall = 1.
  - Otherwise fwd = 0.
  - src == 0 or used = 0: fwd = 0, no stall.
- WAW: id_valid && id_reg_write && id_rd != 0 && cnt[id_rd] != 0 -> stall.
- stall = id_valid && !flush && (stall_a || stall_b || waw).
- forward_a and forward_b are forced to 0 when !id_valid.
- accept = id_valid && !stall && !flush.
- Scoreboard, per cycle:
  - Every nonzero cnt[r] decrements by 1.
  - If accept && id_reg_write && id_rd != 0 && id_lat != 0: cnt[id_rd] <= min(id_lat, MAX_LAT). This overrides the decrement.
  - cnt[0] is always 0.
- Timing: stall uses the registered cnt. An entry reaching 0 at edge T releases dependants in cycle T+1. Result is written to the regfile at the cycle cnt goes 1->0 (external writeback contract). No same-cycle bypass.
- Flush: blocks accept and suppresses stall that cycle. Existing scoreboard entries are retained (already-issued long ops complete).
- stall_count: +1 on each cycle with stall=1; saturates at 32'hFFFF_FFFF; cleared only by rst.
- rst mid-operation: all pending entries dropped next cycle.

Decomposition:
- Package fwd_pkg holds:
  - FWD_RF = 0.
  - Function fwd_code(i) = NUM_STAGES-i.
  - Localparams for the legacy 2-stage codes FWD_EXMEM = 2'b10 and FWD_MEMWB = 2'b01.
- Sub-module fwd_src_resolve: one source register against the stage vectors plus the cnt-busy bit; outputs fwd and src_stall. Instantiated twice (rs1, rs2).
- Top level holds the counter array, WAW check, stall_count.

Test Plan:
- Stage0 rd=5 write, data_ok=1; stage1 rd=5 write; id rs1=5 -> forward_a=2'b10, stall=0 (youngest wins).
- Stage1 only rd=7 write, data_ok=1; rs2=7 -> forward_b=2'b01. Repeat with rd=0 -> forward_b=0.
- Load-use: stage0 rd=3, data_ok=0, stage1 rd=3 data_ok=1; rs1=3 -> stall=1, forward_a=0; next cycle data_ok=1 -> forward_a=2'b10, stall=0, stall_count=1.
- Long op: accept rd=9, id_lat=4; dependent rs1=9 follows -> stall for 4 cycles, sb_busy[9] high 4 cycles, released 5th cycle. id_lat=12 with MAX_LAT=8 -> 8 cycles.
- WAW plus flush: rd=9 busy, new id rd=9 -> stall=1; same with flush=1 -> stall=0, no scoreboard write, cnt[9] keeps decrementing.
- rst asserted with cnt[9]=3 -> next cycle sb_busy=0, stall_count=0. Also run NUM_STAGES=3 with a stage2 hit -> forward code 1, stage0 hit -> code 3.
